// File: rtl/apb_master_mux.sv
// APB master bridge: one valid/ready command at a time, routed to one of NUM_SLV slaves by the upper address bits.
// Latency: a zero-wait transfer answers three cycles after accept; a decode error answers one cycle after accept.
// Backpressure: cmd_ready is high only while idle and out of reset; a slave stretches ACCESS by holding PREADY low.
// Optional APB_TIMEOUT_EN: abort a transfer with rsp_err once ACCESS has waited TIMEOUT cycles.
module apb_master_mux #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam logic [SEL_W:0] NUM_SLV_L = NUM_SLV[SEL_W:0];

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [SEL_W-1:0]    cmd_idx;
  logic                decode_err;
  logic                pready_sel;
  logic                pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;

  // Decode the incoming command and pick out the active slave's response lines.
  always_comb begin
    cmd_idx     = cmd_addr[ADDR_W-1 -: SEL_W];
    decode_err  = ({1'b0, cmd_idx} >= NUM_SLV_L);
    pready_sel  = PREADY[idx_q];
    pslverr_sel = PSLVERR[idx_q];
    prdata_sel  = PRDATA[idx_q*DATA_W +: DATA_W];
    cmd_ready   = (state_q == S_IDLE) & ~PRESET;
  end

  // Next-state and register update logic for the SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (decode_err) begin
            // Unmapped slave: answer immediately without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            idx_d    = cmd_idx;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            pwrite_d = cmd_write;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (pready_sel) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_sel;
          rsp_rdata_d = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
          state_d     = S_IDLE;
`ifdef APB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Slave never answered: give up and report an error.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Bus outputs come straight from registered state.
  always_comb begin
    PSEL = '0;
    if (state_q != S_IDLE) PSEL[idx_q] = 1'b1;
    PENABLE   = (state_q == S_ACCESS);
    PADDR     = paddr_q;
    PWDATA    = pwdata_q;
    PWRITE    = pwrite_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Bench for apb_master_mux: a 4-slave instance driven from a vector table plus hand sequences,
// and a 3-slave instance for the unmapped-address path.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_master_mux;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, PWRITE, PENABLE;
  logic [7:0]  rsp_rdata, PADDR, PWDATA;
  logic [3:0]  PSEL, PREADY, PSLVERR;
  logic [31:0] PRDATA;

  logic        c3_valid, c3_ready, c3_write;
  logic [7:0]  c3_addr, c3_wdata;
  logic        r3_valid, r3_err, PWRITE3, PENABLE3;
  logic [7:0]  r3_rdata, PADDR3, PWDATA3;
  logic [2:0]  PSEL3, PREADY3, PSLVERR3;
  logic [23:0] PRDATA3;

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_mux #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(16)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  apb_master_mux #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(16)) u_dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
    .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
    .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err),
    .PADDR(PADDR3), .PWDATA(PWDATA3), .PWRITE(PWRITE3), .PSEL(PSEL3), .PENABLE(PENABLE3),
    .PREADY(PREADY3), .PRDATA(PRDATA3), .PSLVERR(PSLVERR3)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          waits;      // ACCESS cycles with the selected PREADY low
    logic        setup_rdy;  // selected PREADY raised during SETUP (must be ignored)
    logic [3:0]  other_rdy;  // PREADY of the other slaves
    logic [3:0]  slverr;
    logic [31:0] prdata;
    logic [3:0]  exp_psel;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer on the 4-slave instance; entered and left 1 unit after an edge.
  task automatic run_vec(input vec_t v);
    PRDATA    = v.prdata;
    PSLVERR   = v.slverr;
    PREADY    = v.other_rdy | (v.setup_rdy ? v.exp_psel : 4'b0000);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("setup_psel", 32'(PSEL), 32'(v.exp_psel));
    chk("setup_penable", 32'(PENABLE), 0);
    chk("setup_paddr", 32'(PADDR), 32'(v.addr));
    chk("setup_pwrite", 32'(PWRITE), 32'(v.wr));
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    PREADY = v.other_rdy;
    tick();
    for (int w = 0; w < v.waits; w++) begin
      chk("wait_penable", 32'(PENABLE), 1);
      chk("wait_psel", 32'(PSEL), 32'(v.exp_psel));
      chk("wait_paddr", 32'(PADDR), 32'(v.addr));
      chk("wait_pwdata", 32'(PWDATA), 32'(v.wdata));
      chk("wait_rsp_valid", 32'(rsp_valid), 0);
      tick();
    end
    chk("access_penable", 32'(PENABLE), 1);
    chk("access_rsp_valid", 32'(rsp_valid), 0);
    PREADY = v.other_rdy | v.exp_psel;
    tick();
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("done_psel", 32'(PSEL), 0);
    chk("done_penable", 32'(PENABLE), 0);
    chk("done_cmd_ready", 32'(cmd_ready), 1);
    PREADY = 4'b0000;
    tick();
    chk("rsp_pulse_end", 32'(rsp_valid), 0);
    chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    // wr addr wdata waits setup_rdy other slverr prdata exp_psel exp_rdata exp_err
    vecs[0] = '{1'b0, 8'h45, 8'h00, 0, 1'b0, 4'b0000, 4'b0000, 32'h1122_A533, 4'b0010, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'hC3, 8'h5A, 3, 1'b0, 4'b0000, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h80, 8'h00, 2, 1'b0, 4'b0001, 4'b0100, 32'h00C7_0000, 4'b0100, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h3C, 8'h00, 1, 1'b1, 4'b1110, 4'b1110, 32'hDEAD_BE7E, 4'b0001, 8'h7E, 1'b0};
    vecs[4] = '{1'b1, 8'h7F, 8'h81, 0, 1'b0, 4'b0000, 4'b0010, 32'h0000_9900, 4'b0010, 8'h00, 1'b1};

    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    PREADY = 4'b0000; PSLVERR = 4'b0000; PRDATA = 32'h0;
    c3_valid = 1'b0; c3_write = 1'b0; c3_addr = 8'h00; c3_wdata = 8'h00;
    PREADY3 = 3'b000; PSLVERR3 = 3'b000; PRDATA3 = 24'h0;
    tick();
    tick();
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    chk("rst_pwdata", 32'(PWDATA), 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    PRESET = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Busy master ignores a new command, then reset during ACCESS aborts silently.
    PREADY = 4'b0000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h45;
    tick();
    cmd_addr = 8'hC3; cmd_write = 1'b1;
    chk("busy_paddr_setup", 32'(PADDR), 32'h45);
    tick();
    chk("busy_paddr_access", 32'(PADDR), 32'h45);
    chk("busy_pwrite_access", 32'(PWRITE), 0);
    chk("busy_penable", 32'(PENABLE), 1);
    cmd_valid = 1'b0;
    PRESET = 1'b1;
    tick();
    chk("abort_psel", 32'(PSEL), 0);
    chk("abort_penable", 32'(PENABLE), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_paddr", 32'(PADDR), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 0);
    PRESET = 1'b0;
    tick();
    chk("abort_no_late_rsp", 32'(rsp_valid), 0);
    run_vec(vecs[0]);

    // Unmapped slave on the 3-slave instance, then an immediate back-to-back read.
    c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 8'hC0;
    PREADY3 = 3'b100; PRDATA3 = 24'h3C_0000;
    tick();
    chk("dec_psel", 32'(PSEL3), 0);
    chk("dec_penable", 32'(PENABLE3), 0);
    chk("dec_rsp_valid", 32'(r3_valid), 1);
    chk("dec_rsp_err", 32'(r3_err), 1);
    chk("dec_rsp_rdata", 32'(r3_rdata), 0);
    chk("dec_cmd_ready", 32'(c3_ready), 1);
    c3_addr = 8'h80;
    tick();
    c3_valid = 1'b0;
    chk("dec_next_psel", 32'(PSEL3), 32'b100);
    chk("dec_next_rsp_pulse_end", 32'(r3_valid), 0);
    tick();
    chk("dec_next_penable", 32'(PENABLE3), 1);
    tick();
    chk("dec_next_rsp_valid", 32'(r3_valid), 1);
    chk("dec_next_rsp_rdata", 32'(r3_rdata), 32'h3C);
    chk("dec_next_rsp_err", 32'(r3_err), 0);

    // Slave that never answers.
    PREADY = 4'b0000; PSLVERR = 4'b0000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h80;
    tick();
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 120) begin
      tick();
      n++;
    end
`ifdef APB_TIMEOUT_EN
    chk("tmo_rsp_valid", 32'(rsp_valid), 1);
    chk("tmo_latency", 32'(n), 19);
    chk("tmo_rsp_err", 32'(rsp_err), 1);
    chk("tmo_rsp_rdata", 32'(rsp_rdata), 0);
    chk("tmo_psel", 32'(PSEL), 0);
`else
    chk("hang_no_rsp", 32'(rsp_valid), 0);
    chk("hang_psel", 32'(PSEL), 32'b0100);
    chk("hang_penable", 32'(PENABLE), 1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("hang_reset_psel", 32'(PSEL), 0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
